accel_poll_sequencer: RTL and testbench
=======================================

ACCEL_POLL_SEQUENCER -- requirements
Module: accel_poll_sequencer

Interface
REQ-001 SHALL have parameter SYS_CLK_SPEED, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE_HZ, default 100, poll rate; PERIOD = SYS_CLK_SPEED/SAMPLE_RATE_HZ cycles.
REQ-003 SHALL have parameter DEV_ADDRESS, default 7'h1D, accelerometer 7-bit I2C address.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max cycles from start to finished per transaction.
REQ-005 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ready  input  1  I2C controller idle and able to accept start.
REQ-008 i2c_comms_finished  input  1  one-cycle pulse, current transaction done.
REQ-009 READ_DATA  input  8  read byte, valid in the cycle i2c_comms_finished is high.
REQ-010 start_i2c_comms  output  1  one-cycle transaction request.
REQ-011 DEV_ADDR  output  7  device address, constant DEV_ADDRESS.
REQ-012 REG_ADDR  output  8  target register.
REQ-013 R_W  output  1  1 = read, 0 = write.
REQ-014 WRITE_DATA  output  8  write byte.
REQ-015 accel_x, accel_y, accel_z  output  16 each  signed axis samples, {DATAn1, DATAn0}.
REQ-016 sample_valid  output  1  one-cycle pulse, new x/y/z set published.
REQ-017 error  output  1  sticky transaction-timeout flag.
REQ-018 busy  output  1  high whenever a transaction is outstanding.

Function
REQ-019 FSM states SHALL be IDLE, CFG_ISSUE, CFG_WAIT, POLL_WAIT, RD_ISSUE, RD_WAIT, PUBLISH, ERROR.
REQ-020 Config table SHALL be, in order: write 0x31 <= 0x08 (DATA_FORMAT full-res), write 0x2D <= 0x08 (POWER_CTL measure).
REQ-021 Read table SHALL be registers 0x32..0x37 (X0,X1,Y0,Y1,Z0,Z1), one single-byte read each.
REQ-022 IDLE SHALL go to CFG_ISSUE the cycle after reset deasserts.
REQ-023 *_ISSUE states SHALL drive REG_ADDR/R_W/WRITE_DATA for the current entry and assert start_i2c_comms for exactly one cycle, only in a cycle with ready high; otherwise wait.
REQ-024 REG_ADDR, R_W, WRITE_DATA SHALL be held stable from the start cycle through the finished cycle.
REQ-025 *_WAIT states SHALL ignore ready and advance only on i2c_comms_finished.
REQ-026 CFG_WAIT on finished: next config entry -> CFG_ISSUE; after last entry -> POLL_WAIT.
REQ-027 RD_WAIT on finished: capture READ_DATA into byte slot index; index<5 -> RD_ISSUE with index+1; index==5 -> PUBLISH.
REQ-028 POLL_WAIT SHALL load a counter with PERIOD-1 on entry and go to RD_ISSUE (index 0) when it reaches 0; the first poll after config SHALL also wait a full PERIOD.
REQ-029 PUBLISH SHALL update accel_x/y/z simultaneously from the six captured bytes, pulse sample_valid for one cycle, then go to POLL_WAIT.
REQ-030 accel_x/y/z SHALL not change except in PUBLISH; partial read sets are never visible.
REQ-031 A timeout counter SHALL clear on each start and, if TIMEOUT_CYCLES elapse in a *_WAIT state without finished, go to ERROR.
REQ-032 ERROR SHALL set error=1, issue no further starts, and be left only by reset.
REQ-033 A finished pulse arriving outside a *_WAIT state SHALL be ignored.
REQ-034 busy SHALL be high from the start cycle up to and including the finished cycle.

Reset
REQ-035 On rst: state=IDLE, start_i2c_comms=0, REG_ADDR=0, R_W=0, WRITE_DATA=0, accel_x/y/z=0, sample_valid=0, error=0, busy=0, counters and indices cleared.
REQ-036 Reset asserted mid-transaction SHALL abort immediately; after release the sequence restarts from the first config write.

Verification
REQ-037 Reset release, ready=1, controller model finishing 100 cycles after each start -> write 0x31/0x08 then write 0x2D/0x08, R_W=0, one start each.
REQ-038 SAMPLE_RATE_HZ giving PERIOD=1000, model returns bytes 0x01,0x02,0x03,0x04,0x05,0x06 -> reads 0x32..0x37 in order; accel_x=0x0201, accel_y=0x0403, accel_z=0x0605, single sample_valid pulse.
REQ-039 Hold ready=0 for 50 cycles at an issue point -> no start until ready rises; outputs stable throughout.
REQ-040 Model never returns finished, TIMEOUT_CYCLES=500 -> error=1 at cycle 500 after start, no further starts.
REQ-041 Assert rst during 4th read -> all outputs to reset values at once; after release, config writes reissued; previous accel_x/y/z not republished.
REQ-042 Spurious finished pulse while in POLL_WAIT -> no state change, no capture, no sample_valid.

Source files
------------

// File: rtl/accel_poll_sequencer.sv
// ---------------------------------------------------------------------------
// accel_poll_sequencer
//
// Drives an I2C byte controller to configure an accelerometer and then poll
// its six data registers at a fixed rate. The FSM first writes DATA_FORMAT
// (0x31 <= 0x08) and POWER_CTL (0x2D <= 0x08). It then waits one poll period
// and reads 0x32..0x37, one byte per transaction. After the sixth byte it
// publishes the X/Y/Z samples together.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   ready                controller idle; a start is only issued while high
//   i2c_comms_finished   one-cycle done pulse from the controller
//   READ_DATA            read byte, valid with i2c_comms_finished
//   start_i2c_comms      one-cycle transaction request
//   DEV_ADDR             constant 7-bit device address
//   REG_ADDR/R_W/        operands for the current transaction, held from
//   WRITE_DATA           the start cycle through the finished cycle
//   accel_x/y/z          signed samples {DATAn1, DATAn0}
//   sample_valid         one-cycle pulse when a new x/y/z set is visible
//   error                sticky transaction timeout (cleared only by reset)
//   busy                 a transaction is outstanding
// ---------------------------------------------------------------------------
module accel_poll_sequencer #(
  parameter int         SYS_CLK_SPEED  = 50000000,
  parameter int         SAMPLE_RATE_HZ = 100,
  parameter logic [6:0] DEV_ADDRESS    = 7'h1D,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic        i2c_comms_finished,
  input  logic [7:0]  READ_DATA,
  output logic        start_i2c_comms,
  output logic [6:0]  DEV_ADDR,
  output logic [7:0]  REG_ADDR,
  output logic        R_W,
  output logic [7:0]  WRITE_DATA,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        error,
  output logic        busy
);

  localparam int PERIOD = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
  localparam int PW     = $clog2(PERIOD + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] POLL_RELOAD = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    CFG_LAST    = 3'd1;
  localparam logic [2:0]    RD_LAST     = 3'd5;

  typedef enum logic [2:0] {
    IDLE, CFG_ISSUE, CFG_WAIT, POLL_WAIT, RD_ISSUE, RD_WAIT, PUBLISH, ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [TW-1:0]   to_q, to_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic            r_w_q, r_w_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [5:0][7:0] bytes_q;
  logic [15:0]     ax_q, ay_q, az_q;
  logic            sv_q;
  logic            cap_en;

  // Next state and operand selection
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    poll_d          = poll_q;
    to_d            = to_q;
    reg_addr_d      = reg_addr_q;
    r_w_d           = r_w_q;
    wdata_d         = wdata_q;
    start_i2c_comms = 1'b0;
    cap_en          = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = CFG_ISSUE;
        idx_d   = 3'd0;
      end

      CFG_ISSUE, RD_ISSUE: begin
        if (ready) begin
          start_i2c_comms = 1'b1;
          // Counts cycles elapsed since the start, so the value seen in
          // the k-th wait cycle is k.
          to_d    = TW'(1);
          state_d = (state_q == CFG_ISSUE) ? CFG_WAIT : RD_WAIT;
        end
      end

      CFG_WAIT: begin
        if (i2c_comms_finished) begin
          if (idx_q == CFG_LAST) begin
            state_d = POLL_WAIT;
            poll_d  = POLL_RELOAD;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = CFG_ISSUE;
          end
        end else if (to_q == TO_LAST) begin
          state_d = ERROR;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      POLL_WAIT: begin
        // A finished pulse here is deliberately ignored.
        if (poll_q == '0) begin
          state_d = RD_ISSUE;
          idx_d   = 3'd0;
        end else begin
          poll_d = poll_q - PW'(1);
        end
      end

      RD_WAIT: begin
        if (i2c_comms_finished) begin
          cap_en = 1'b1;
          if (idx_q == RD_LAST) begin
            state_d = PUBLISH;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = RD_ISSUE;
          end
        end else if (to_q == TO_LAST) begin
          state_d = ERROR;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      PUBLISH: begin
        state_d = POLL_WAIT;
        poll_d  = POLL_RELOAD;
      end

      ERROR: state_d = ERROR;

      default: state_d = IDLE;
    endcase

    // Operands are loaded on the way into an issue state. They then stay
    // untouched through the whole wait, which keeps them stable until finished.
    if (state_d == CFG_ISSUE) begin
      reg_addr_d = (idx_d == 3'd0) ? 8'h31 : 8'h2D;
      r_w_d      = 1'b0;
      wdata_d    = 8'h08;
    end else if (state_d == RD_ISSUE) begin
      reg_addr_d = 8'h32 + {5'b0, idx_d};
      r_w_d      = 1'b1;
      wdata_d    = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      poll_q     <= '0;
      to_q       <= '0;
      reg_addr_q <= '0;
      r_w_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_q     <= poll_d;
      to_q       <= to_d;
      reg_addr_q <= reg_addr_d;
      r_w_q      <= r_w_d;
      wdata_q    <= wdata_d;
    end
  end

  // Byte capture and publish. The sample registers are written only in
  // PUBLISH, so a partial read set never becomes visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_q <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      az_q    <= '0;
      sv_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (cap_en && idx_q == 3'(i)) bytes_q[i] <= READ_DATA;
      end
      sv_q <= (state_q == PUBLISH);
      if (state_q == PUBLISH) begin
        ax_q <= {bytes_q[1], bytes_q[0]};
        ay_q <= {bytes_q[3], bytes_q[2]};
        az_q <= {bytes_q[5], bytes_q[4]};
      end
    end
  end

  assign DEV_ADDR     = DEV_ADDRESS;
  assign REG_ADDR     = reg_addr_q;
  assign R_W          = r_w_q;
  assign WRITE_DATA   = wdata_q;
  assign accel_x      = ax_q;
  assign accel_y      = ay_q;
  assign accel_z      = az_q;
  assign sample_valid = sv_q;
  assign error        = (state_q == ERROR);
  assign busy         = start_i2c_comms || (state_q == CFG_WAIT) || (state_q == RD_WAIT);

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Bench for accel_poll_sequencer. It uses a controller model with 100-cycle
// latency and a scoreboard of expected transactions and samples. It covers
// the spurious finished pulse, a ready stall, a mid-read reset and a timeout.
module tb_accel_poll_sequencer;
  localparam int PERIOD = 1000;
  localparam int LAT    = 100;
  localparam int TMO    = 500;

  logic        clk = 1'b0, rst = 1'b1, ready = 1'b1, fin = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        start_i2c_comms, R_W, sample_valid, error, busy;
  logic [6:0]  DEV_ADDR;
  logic [7:0]  REG_ADDR, WRITE_DATA;
  logic [15:0] accel_x, accel_y, accel_z;

  accel_poll_sequencer #(
    .SYS_CLK_SPEED(100000), .SAMPLE_RATE_HZ(100),
    .DEV_ADDRESS(7'h1D), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .i2c_comms_finished(fin),
    .READ_DATA(rdata), .start_i2c_comms(start_i2c_comms), .DEV_ADDR(DEV_ADDR),
    .REG_ADDR(REG_ADDR), .R_W(R_W), .WRITE_DATA(WRITE_DATA),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [16:0] exp_txn[$];   // {R_W, REG_ADDR, WRITE_DATA}
  logic [47:0] exp_smp[$];   // {x, y, z}

  task automatic push_cfg();
    exp_txn.push_back({1'b0, 8'h31, 8'h08});
    exp_txn.push_back({1'b0, 8'h2D, 8'h08});
  endtask

  task automatic push_rd(input int n);
    for (int s = 0; s < n; s++)
      for (int k = 0; k < 6; k++) exp_txn.push_back({1'b1, 8'(8'h32 + k), 8'h00});
  endtask

  function automatic logic [7:0] pat(input int n, input int k);
    if (n == 0) return 8'(k + 1);
    if (n == 1) begin
      case (k)
        0: return 8'h00; 1: return 8'h80; 2: return 8'hFF;
        3: return 8'h7F; 4: return 8'h34; default: return 8'h12;
      endcase
    end
    return 8'(n * 37 + k * 11);
  endfunction

  // Shared between the model/monitor and the main sequence (single writer each)
  int   n_start = 0, n_sv = 0, last_start = 0, err_cyc = -1, last_cfg_fin = -1, last_sv = -1;
  int   spur_req = 0, spur_done = 0, pat_n = 0;
  logic [7:0] last_reg = 8'h00;
  logic hang = 1'b0, chk_delta = 1'b1;

  // Controller model and output monitor, both on the falling edge
  initial begin : model
    int cnt, k;
    bit active;
    logic sv_prev;
    logic [16:0] hold, e;
    logic [7:0] b [6];
    active = 0; cnt = 0; sv_prev = 0; hold = '0;
    forever begin
      @(negedge clk);
      fin = 1'b0;
      if (rst) begin
        active = 0; sv_prev = 0; last_sv = -1;
        continue;
      end
      if (error && err_cyc < 0) err_cyc = cyc;
      if (sample_valid) begin
        n_sv++;
        last_sv = cyc;
        chk("sv_pulse_width", sv_prev, 1'b0);
        if (exp_smp.size() == 0) chk("sv_unexpected", 1'b1, 1'b0);
        else chk("sample", {accel_x, accel_y, accel_z}, exp_smp.pop_front());
      end
      sv_prev = sample_valid;
      if (start_i2c_comms) begin
        n_start++;
        last_start = cyc;
        last_reg = REG_ADDR;
        chk("busy_at_start", busy, 1'b1);
        chk("dev_addr", DEV_ADDR, 7'h1D);
        if (exp_txn.size() == 0) chk("start_unexpected", 1'b1, 1'b0);
        else begin
          e = exp_txn.pop_front();
          chk("txn", {R_W, REG_ADDR, (e[16] ? 8'h00 : WRITE_DATA)}, e);
        end
        if (R_W && REG_ADDR == 8'h32 && chk_delta) begin
          if (last_sv >= 0) chk("poll_gap_after_sample", cyc - last_sv, PERIOD);
          else chk("poll_gap_after_cfg", cyc - last_cfg_fin, PERIOD + 1);
        end
        hold = {R_W, REG_ADDR, WRITE_DATA};
        active = 1; cnt = LAT;
      end else if (active) begin
        if (!hang) begin
          cnt--;
          if (cnt == 0) begin
            active = 0;
            chk("operands_held", {R_W, REG_ADDR, WRITE_DATA}, hold);
            chk("busy_at_finish", busy, 1'b1);
            fin = 1'b1;
            if (hold[16]) begin
              k = int'(hold[15:8]) - 'h32;
              rdata = pat(pat_n, k);
              b[k] = rdata;
              if (k == 5) begin
                exp_smp.push_back({b[1], b[0], b[3], b[2], b[5], b[4]});
                pat_n++;
              end
            end else begin
              rdata = 8'h00;
              if (hold[15:8] == 8'h2D) last_cfg_fin = cyc;
            end
          end
        end
      end else if (spur_req != spur_done) begin
        spur_done = spur_req;
        fin = 1'b1;
        rdata = 8'hEE;
      end
    end
  end

  task automatic wait_sv(input int n, input int budget);
    int t = 0;
    while (n_sv < n && t < budget) begin @(posedge clk); t++; end
    chk("wait_sample_valid", n_sv >= n, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, start_i2c_comms, 1'b0);
    chk({tag, "_regaddr"}, REG_ADDR, 8'h00);
    chk({tag, "_rw_wdata"}, {R_W, WRITE_DATA}, 9'h000);
    chk({tag, "_accel"}, {accel_x, accel_y, accel_z}, 48'h0);
    chk({tag, "_sv_err_busy"}, {sample_valid, error, busy}, 3'b000);
  endtask

  initial begin : main
    int s, t;
    logic bad_start, bad_hold;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Config, three samples; the first read set uses the 0x01..0x06 pattern
    push_cfg();
    push_rd(3);
    @(posedge clk); #1 rst = 1'b0;
    wait_sv(1, 4000);
    @(negedge clk);
    chk("x0", accel_x, 16'h0201);
    chk("y0", accel_y, 16'h0403);
    chk("z0", accel_z, 16'h0605);

    // Spurious finished in POLL_WAIT; the next poll timing must be unaffected
    repeat (10) @(posedge clk);
    #1 spur_req++;
    repeat (20) @(posedge clk);
    chk("spur_no_sv", n_sv, 1);
    chk("spur_no_start", n_start, 8);
    wait_sv(2, 3000);

    // Hold ready low across the read issue point
    repeat (993) @(posedge clk);
    #1 ready = 1'b0;
    chk_delta = 1'b0;
    s = n_start;
    bad_start = 1'b0; bad_hold = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bad_start |= start_i2c_comms;
      if (i >= 10) bad_hold |= (REG_ADDR !== 8'h32) || (R_W !== 1'b1) || (busy !== 1'b0);
    end
    chk("no_start_ready_low", bad_start, 1'b0);
    chk("stable_ready_low", bad_hold, 1'b0);
    chk("start_count_ready_low", n_start, s);
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    chk("start_on_ready_rise", start_i2c_comms, 1'b1);
    wait_sv(3, 3000);
    chk_delta = 1'b1;

    // Reset during the 4th read of the next set
    push_rd(1);
    s = n_start;
    t = 0;
    while (!(n_start >= s + 4 && last_reg == 8'h35) && t < 3000) begin @(posedge clk); t++; end
    chk("reach_4th_read", last_reg, 8'h35);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midread_reset");
    exp_txn.delete();
    exp_smp.delete();
    push_cfg();
    push_rd(1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (400) @(posedge clk);
    chk("cfg_reissued", n_start, s + 4 + 2);
    chk("no_republish", {accel_x, accel_y, accel_z}, 48'h0);
    chk("no_sv_after_reset", n_sv, 3);
    wait_sv(4, 3000);

    // Timeout: the controller never finishes the next read
    #1 hang = 1'b1;
    exp_txn.push_back({1'b1, 8'h32, 8'h00});
    t = 0;
    while (err_cyc < 0 && t < 3000) begin @(posedge clk); t++; end
    chk("timeout_cycle", err_cyc - last_start, TMO);
    s = n_start;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("no_start_after_error", n_start, s);
    chk("error_sticky_busy", {error, busy}, 2'b10);
    chk("txn_queue_drained", exp_txn.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
